// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the two mux sources and the select arbiter.
// Sources drive requests and release; the arbiter returns select, grants and busy.
interface mux_sel_arbiter_if;
  logic req_a;
  logic req_b;
  logic done;
  logic sel;
  logic gnt_a;
  logic gnt_b;
  logic busy;

  modport master (
    output req_a, req_b, done,
    input  sel, gnt_a, gnt_b, busy
  );

  modport slave (
    input  req_a, req_b, done,
    output sel, gnt_a, gnt_b, busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin 2:1 mux select arbiter with bounded hold under contention; 1-cycle req-to-grant.
// Owner keeps the path until done/req drop, or MAX_HOLD cycles while the other source waits.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic             SRC_A     = 1'b0;
  localparam logic             SRC_B     = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             busy_q, busy_d;

  logic take_a;
  logic take_b;
  logic release_own;
  logic preempt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    take_a      = 1'b0;
    take_b      = 1'b0;
    release_own = 1'b0;
    preempt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the source that did not own last goes first.
        take_a = bus.req_a && (!bus.req_b || last_q == SRC_B);
        take_b = bus.req_b && !take_a;
      end
      OWN_A: begin
        release_own = bus.done || !bus.req_a;
        preempt     = bus.req_b && (cnt_q == HOLD_LAST) && !release_own;
        if (release_own || preempt) begin
          take_b = bus.req_b;
          if (!bus.req_b) state_d = IDLE;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OWN_B: begin
        release_own = bus.done || !bus.req_b;
        preempt     = bus.req_a && (cnt_q == HOLD_LAST) && !release_own;
        if (release_own || preempt) begin
          take_a = bus.req_a;
          if (!bus.req_a) state_d = IDLE;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_a) begin
      state_d = OWN_A;
      cnt_d   = '0;
      last_d  = SRC_A;
      sel_d   = SRC_A;
    end
    if (take_b) begin
      state_d = OWN_B;
      cnt_d   = '0;
      last_d  = SRC_B;
      sel_d   = SRC_B;
    end

    // sel is not touched on a drop to IDLE so the mux keeps its last source.
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    busy_d  = gnt_a_d | gnt_b_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_B;
      sel_q   <= SRC_A;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Vector-table bench for mux_sel_arbiter: MAX_HOLD=4 main instance, MAX_HOLD=1 alternation instance.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;

  always #5 clk = ~clk;

  mux_sel_arbiter_if bus0 ();
  mux_sel_arbiter_if bus1 ();

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0.slave)
  );

  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1.slave)
  );

  typedef struct packed {
    logic rst_n;
    logic a;
    logic b;
    logic d;
    logic sel;
    logic ga;
    logic gb;
  } vec_t;

  typedef struct packed {
    logic sel;
    logic ga;
    logic gb;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  vec_t tbl[$];

  function automatic vec_t v(input logic r, a, b, d, s, ga, gb);
    vec_t t;
    t = '{rst_n: r, a: a, b: b, d: d, sel: s, ga: ga, gb: gb};
    return t;
  endfunction

  task automatic check(input int u, input string name);
    exp_t       e;
    logic [3:0] act;
    logic [3:0] req;
    checks++;
    if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
      errors++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      e   = (u == 0) ? sb0.pop_front() : sb1.pop_front();
      act = (u == 0) ? {bus0.sel, bus0.gnt_a, bus0.gnt_b, bus0.busy}
                     : {bus1.sel, bus1.gnt_a, bus1.gnt_b, bus1.busy};
      req = {e.sel, e.ga, e.gb, e.ga | e.gb};
      if (act !== req) begin
        errors++;
        $display("FAIL %s: {sel,gnt_a,gnt_b,busy} got %b want %b", name, act, req);
      end
    end
  endtask

  task automatic step(input int u, input vec_t t, input string name);
    @(negedge clk);
    if (u == 0) begin
      rst0_n = t.rst_n; bus0.req_a = t.a; bus0.req_b = t.b; bus0.done = t.d;
      sb0.push_back('{sel: t.sel, ga: t.ga, gb: t.gb});
    end else begin
      rst1_n = t.rst_n; bus1.req_a = t.a; bus1.req_b = t.b; bus1.done = t.d;
      sb1.push_back('{sel: t.sel, ga: t.ga, gb: t.gb});
    end
    @(posedge clk);
    #1;
    check(u, name);
  endtask

  initial begin
    bus0.req_a = 1'b0; bus0.req_b = 1'b0; bus0.done = 1'b0;
    bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.done = 1'b0;

    //               rst a  b  d  sel ga gb
    // reset held with both requesting
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    // contention: A x4, B x4, A again, no bubble
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    // lone B for 6 cycles, then done; sel stays 1 in IDLE, done in IDLE ignored
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0));
    // early release by done at cnt=1 hands straight to B, then IDLE
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    // fairness: lone A, lone B, tie -> A; lone A, tie -> B
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    // counter saturates while uncontended; late req_b switches on next edge
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    // done coinciding with preempt behaves as release
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
    // B owns up to cnt=2 ahead of the mid-ownership reset sequence
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset pulse between edges while B owns
    @(negedge clk);
    #1;
    rst0_n = 1'b0;
    bus0.req_a = 1'b1;
    bus0.req_b = 1'b1;
    #1;
    sb0.push_back('{sel: 1'b0, ga: 1'b0, gb: 1'b0});
    check(0, "async_reset_drop");
    #1;
    rst0_n = 1'b1;
    @(posedge clk);
    #1;
    sb0.push_back('{sel: 1'b0, ga: 1'b1, gb: 1'b0});
    check(0, "post_reset_a_first");
    step(0, v(1, 0, 0, 0, 0, 0, 0), "post_reset_idle");

    // MAX_HOLD=1: ownership alternates every cycle under contention
    step(1, v(0, 1, 1, 0, 0, 0, 0), "mh1_reset");
    for (int i = 0; i < 8; i++) begin
      step(1, v(1, 1, 1, 0, logic'(i % 2), logic'(i % 2 == 0), logic'(i % 2)),
           $sformatf("mh1_alt%0d", i));
    end
    step(1, v(1, 0, 0, 0, 1, 0, 0), "mh1_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
